// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Write-back arbiter, registered write stage and pending-bit
//               scoreboard for the register table. Define REGFILE_ARB_RR_EN
//               for round-robin grant; the default is fixed priority (0 first).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        rsv_valid,
    input  logic [ADDR_W-1:0]           rsv_reg,
    output logic                        rsv_ready,
    input  logic [ADDR_W-1:0]           rs_a,
    input  logic [ADDR_W-1:0]           rs_b,
    output logic                        haz_a,
    output logic                        haz_b,
    output logic                        write_register_d,
    output logic [ADDR_W-1:0]           register_d,
    output logic [DATA_W-1:0]           data_register_d_in,
    output logic [(2**ADDR_W)-1:0]      busy_vec
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_any_grant;
    logic [ADDR_W-1:0]   w_sel_reg;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [NUM_REGS-1:0] r_busy;

`ifdef REGFILE_ARB_RR_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // r_ptr holds the index where the next search starts (last grantee + 1),
    // so out of reset requester 0 is searched first.
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gidx;

    always_comb begin
        w_grant     = '0;
        w_any_grant = 1'b0;
        w_gidx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_any_grant && req_valid[idx]) begin
                w_grant[idx] = 1'b1;
                w_gidx       = idx[PTR_W-1:0];
                w_any_grant  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_any_grant) begin
            r_ptr <= (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
        end
    end
`else
    always_comb begin
        w_grant     = '0;
        w_any_grant = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any_grant && req_valid[i]) begin
                w_grant[i]  = 1'b1;
                w_any_grant = 1'b1;
            end
        end
    end
`endif

    // One-hot grant makes an OR-mux sufficient.
    always_comb begin
        w_sel_reg  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_reg  = w_sel_reg  | req_reg[i*ADDR_W +: ADDR_W];
                w_sel_data = w_sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = w_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_register_d   <= 1'b0;
            register_d         <= '0;
            data_register_d_in <= '0;
        end else begin
            write_register_d <= w_any_grant;
            if (w_any_grant) begin
                register_d         <= w_sel_reg;
                data_register_d_in <= w_sel_data;
            end
        end
    end

    assign rsv_ready = ~r_busy[rsv_reg];
    assign haz_a     = r_busy[rs_a];
    assign haz_b     = r_busy[rs_b];
    assign busy_vec  = r_busy;

    // Set cannot hit the register being cleared: rsv_ready is low while busy.
    always_comb begin
        w_busy_next = r_busy;
        if (write_register_d) begin
            w_busy_next[register_d] = 1'b0;
        end
        if (rsv_valid && rsv_ready) begin
            w_busy_next[rsv_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsv_valid;
    logic [ADDR_W-1:0]         rsv_reg;
    logic                      rsv_ready;
    logic [ADDR_W-1:0]         rs_a;
    logic [ADDR_W-1:0]         rs_b;
    logic                      haz_a;
    logic                      haz_b;
    logic                      write_register_d;
    logic [ADDR_W-1:0]         register_d;
    logic [DATA_W-1:0]         data_register_d_in;
    logic [31:0]               busy_vec;

    int checks;
    int errors;

    regfile_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_reg            (req_reg),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .rsv_valid          (rsv_valid),
        .rsv_reg            (rsv_reg),
        .rsv_ready          (rsv_ready),
        .rs_a               (rs_a),
        .rs_b               (rs_b),
        .haz_a              (haz_a),
        .haz_b              (haz_b),
        .write_register_d   (write_register_d),
        .register_d         (register_d),
        .data_register_d_in (data_register_d_in),
        .busy_vec           (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        req_reg[i*ADDR_W +: ADDR_W]  = r;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_reg   = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_reg   = '0;
        rs_a      = '0;
        rs_b      = '0;

        // Reset state
        #3;
        chk("rst_we",    write_register_d, 0);
        chk("rst_reg",   register_d, 0);
        chk("rst_data",  data_register_d_in, 0);
        chk("rst_busy",  busy_vec, 0);
        chk("rst_rsvr",  rsv_ready, 1);
        chk("rst_haz",   {haz_a, haz_b}, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single write
        req_valid = 3'b001;
        set_req(0, 5'd3, 32'hDEADBEEF);
        #1;
        chk("sw_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1;
        chk("sw_we",   write_register_d, 1);
        chk("sw_reg",  register_d, 3);
        chk("sw_data", data_register_d_in, 32'hDEADBEEF);
        tick();
        chk("sw_we_off",   write_register_d, 0);
        chk("sw_reg_hold", register_d, 3);

        // Contention: fixed priority keeps granting requester 0
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'h0000_00A1);
        set_req(1, 5'd2, 32'h0000_00B2);
        set_req(2, 5'd3, 32'h0000_00C3);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ct_ready", req_ready, 3'b001);
            tick();
            chk("ct_we",   write_register_d, 1);
            chk("ct_reg",  register_d, 1);
            chk("ct_data", data_register_d_in, 32'h0000_00A1);
        end
        req_valid = 3'b110;
        #1;
        chk("pri_110", req_ready, 3'b010);
        tick();
        chk("pri_110_reg", register_d, 2);
        req_valid = 3'b100;
        #1;
        chk("pri_100", req_ready, 3'b100);
        tick();
        chk("pri_100_data", data_register_d_in, 32'h0000_00C3);
        req_valid = 3'b000;
        #1;
        chk("pri_000", req_ready, 3'b000);
        tick();
        chk("idle_we", write_register_d, 0);

        // RAW hazard on r5
        rsv_valid = 1'b1;
        rsv_reg   = 5'd5;
        rs_a      = 5'd5;
        #1;
        chk("raw_pre_haz", haz_a, 0);
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("raw_haz_set",  haz_a, 1);
        chk("raw_busy",     busy_vec, 32'h0000_0020);
        chk("raw_rsv_nrdy", rsv_ready, 0);
        req_valid = 3'b010;
        set_req(1, 5'd5, 32'h0000_0055);
        tick();
        req_valid = '0;
        #1;
        chk("raw_we",       write_register_d, 1);
        chk("raw_reg",      register_d, 5);
        chk("raw_haz_hold", haz_a, 1);
        tick();
        chk("raw_haz_clr",  haz_a, 0);
        chk("raw_busy_clr", busy_vec, 0);

        // WAW stall on r7
        rsv_valid = 1'b1;
        rsv_reg   = 5'd7;
        tick();
        chk("waw_busy",    busy_vec, 32'h0000_0080);
        chk("waw_stall",   rsv_ready, 0);
        tick();
        chk("waw_hold",    busy_vec, 32'h0000_0080);
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'h0000_0077);
        tick();
        req_valid = '0;
        #1;
        chk("waw_we",      write_register_d, 1);
        chk("waw_stall2",  rsv_ready, 0);
        tick();
        chk("waw_clr",     busy_vec, 0);
        chk("waw_rdy",     rsv_ready, 1);
        tick();
        chk("waw_reset",   busy_vec, 32'h0000_0080);
        rsv_valid = 1'b0;

        // Simultaneous set r9 / clear r4; r0 behaves as an ordinary register
        rsv_valid = 1'b1;
        rsv_reg   = 5'd4;
        tick();
        rsv_valid = 1'b0;
        req_valid = 3'b100;
        set_req(2, 5'd4, 32'h0000_0044);
        tick();
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_reg   = 5'd9;
        #1;
        chk("sim_pre", busy_vec, 32'h0000_0090);
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("sim_busy", busy_vec, 32'h0000_0280);
        rsv_valid = 1'b1;
        rsv_reg   = 5'd0;
        rs_b      = 5'd0;
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("r0_haz_b", haz_b, 1);
        chk("r0_busy",  busy_vec, 32'h0000_0281);

        // Asynchronous reset between accept and commit
        req_valid = 3'b001;
        set_req(0, 5'd10, 32'h1234_5678);
        tick();
        req_valid = '0;
        #1;
        chk("ar_we_pre", write_register_d, 1);
        reset = 1'b1;
        #1;
        chk("ar_we",   write_register_d, 0);
        chk("ar_busy", busy_vec, 0);
        chk("ar_reg",  register_d, 0);
        chk("ar_data", data_register_d_in, 0);
        #1;
        reset = 1'b0;
        tick();
        chk("ar_we_post", write_register_d, 0);
        chk("ar_busy_post", busy_vec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
